float_argmax_seq: RTL and testbench

//  Sequencer that streams N floats (e.g. output-layer activations) through one registered

---
 rtl/float_argmax_seq_pkg.sv | 14 +
 rtl/float_argmax_seq_greater_than.sv | 35 +++
 rtl/float_argmax_seq.sv | 138 +++++++++++++
 tb/tb_float_argmax_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/float_argmax_seq_pkg.sv
// Shared constants and FSM state type for the float argmax sequencer (half-precision layout).
package float_argmax_seq_pkg;
  localparam int D_LEN = 16;
  localparam int E_BIT = 5;
  localparam int F_BIT = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIRST = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CMP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/float_argmax_seq_greater_than.sv
// Registered sign-magnitude float comparator: gt is float_a > float_b, one cycle later.
module float_argmax_seq_greater_than #(
  parameter int E_BIT = 5,
  parameter int F_BIT = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [E_BIT+F_BIT:0]   float_a,
  input  logic [E_BIT+F_BIT:0]   float_b,
  output logic                   gt
);
  localparam int M_W = E_BIT + F_BIT;

  logic           sign_a, sign_b;
  logic [M_W-1:0] mag_a, mag_b;
  logic           gt_next;

  assign sign_a = float_a[M_W];
  assign sign_b = float_b[M_W];
  assign mag_a  = float_a[M_W-1:0];
  assign mag_b  = float_b[M_W-1:0];

  // Negative operands compare with <=, so equal negatives report gt=1; callers mask ties.
  always_comb begin
    gt_next = 1'b0;
    if (sign_a != sign_b) gt_next = !sign_a;
    else if (!sign_a)     gt_next = (mag_a > mag_b);
    else                  gt_next = (mag_a <= mag_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gt <= 1'b0;
    else        gt <= gt_next;
  end
endmodule

// File: rtl/float_argmax_seq.sv
// Streams N floats through one registered comparator and reports the index of the first maximum.
// Optional macro ARGMAX_VAL_EN adds the max_val output.
module float_argmax_seq
  import float_argmax_seq_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W:0]   n_items,
  input  logic [D_LEN-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] max_idx,
  output logic             empty,
  output logic [2:0]       state_dbg
`ifdef ARGMAX_VAL_EN
  ,
  output logic [D_LEN-1:0] max_val
`endif
);
  // Handshake: an element transfers on any rising edge where in_valid && in_ready;
  // in_valid may be held low indefinitely and in_data is ignored while in_ready is low.
  localparam logic [IDX_W:0] N_MAX = {1'b1, {IDX_W{1'b0}}};

  state_t           state;
  logic [IDX_W:0]   n_r;
  logic [IDX_W:0]   idx_cnt;
  logic [D_LEN-1:0] max_r;
  logic [D_LEN-1:0] cur_r;
  logic [IDX_W-1:0] cur_idx;
  logic             eq_r;
  logic             gt;
  logic             accept;

  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

  float_argmax_seq_greater_than #(.E_BIT(E_BIT), .F_BIT(F_BIT)) u_gt (
    .clk     (clk),
    .rst_n   (rst_n),
    .float_a (in_data),
    .float_b (max_r),
    .gt      (gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      empty    <= 1'b0;
      max_idx  <= '0;
      max_r    <= '0;
      cur_r    <= '0;
      cur_idx  <= '0;
      eq_r     <= 1'b0;
      idx_cnt  <= '0;
      n_r      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_r     <= (n_items > N_MAX) ? N_MAX : n_items;
            empty   <= (n_items == '0);
            max_idx <= '0;
            max_r   <= '0;
            idx_cnt <= '0;
            busy    <= 1'b1;
            if (n_items == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_FIRST;
              in_ready <= 1'b1;
            end
          end
        end
        ST_FIRST: begin
          if (accept) begin
            max_r   <= in_data;
            max_idx <= '0;
            idx_cnt <= {{IDX_W{1'b0}}, 1'b1};
            if (n_r == {{IDX_W{1'b0}}, 1'b1}) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (accept) begin
            cur_r    <= in_data;
            cur_idx  <= idx_cnt[IDX_W-1:0];
            eq_r     <= (in_data == max_r);
            state    <= ST_CMP;
            in_ready <= 1'b0;
          end
        end
        ST_CMP: begin
          // Ties keep the earlier index.
          if (gt && !eq_r) begin
            max_r   <= cur_r;
            max_idx <= cur_idx;
          end
          idx_cnt <= idx_cnt + 1'b1;
          if (idx_cnt == n_r - 1'b1) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state    <= ST_WAIT;
            in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARGMAX_VAL_EN
  assign max_val = max_r;
`endif
endmodule

// File: tb/tb_float_argmax_seq.sv
// Randomized self-checking bench for float_argmax_seq against a value-ordering reference model.
module tb_float_argmax_seq;
  localparam int IDX_W = 4;
  localparam int NMAX  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W:0]   n_items = '0;
  logic [15:0]      in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] max_idx;
  logic             empty;
  logic [2:0]       state_dbg;
`ifdef ARGMAX_VAL_EN
  logic [15:0]      max_val;
`endif

  float_argmax_seq #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_items   (n_items),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .max_idx   (max_idx),
    .empty     (empty),
    .state_dbg (state_dbg)
`ifdef ARGMAX_VAL_EN
    ,
    .max_val   (max_val)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] items [0:31];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ordering: map each half to a signed integer rank; -0 ranks just below +0.
  function automatic int rank(input logic [15:0] v);
    if (v[15]) return -int'(v[14:0]) - 1;
    else       return int'(v[14:0]);
  endfunction

  // Pushes expected {max value, index} for the first n items (n already clamped).
  task automatic model_push(input int n);
    int best;
    best = 0;
    for (int k = 1; k < n; k++)
      if (rank(items[k]) > rank(items[best])) best = k;
    exp_q.push_back({items[best], 16'(best)});
  endtask

  // Driver: one run; gap_max random idle cycles between elements, optional start pokes while busy.
  task automatic do_run(input string tag, input int n, input int gap_max, input bit poke_start);
    int n_eff, cyc, i, gap, first_acc, done_cyc, busy_low;
    bit hs, rdy_seen;
    logic [31:0] e;
    n_eff = (n > NMAX) ? NMAX : n;
    if (n_eff > 0) model_push(n_eff);
    else           exp_q.push_back(32'h0);
    @(posedge clk); #1;
    start = 1'b1; n_items = (IDX_W+1)'(n);
    @(posedge clk); #1;
    start = 1'b0; n_items = (IDX_W+1)'($urandom_range(0, 31));
    cyc = 0; i = 0; gap = $urandom_range(0, gap_max);
    first_acc = -1; done_cyc = -1; busy_low = 0; rdy_seen = 1'b0;
    while (done_cyc < 0 && cyc < 400) begin
      if (i < n_eff && gap == 0) begin in_valid = 1'b1; in_data = items[i]; end
      else begin in_valid = 1'b0; in_data = 16'($urandom); end
      if (poke_start) start = (cyc % 3 == 1);
      @(negedge clk);
      if (done) done_cyc = cyc;
      if (!busy) busy_low++;
      if (in_ready) rdy_seen = 1'b1;
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        if (first_acc < 0) first_acc = cyc;
        i++;
        gap = $urandom_range(0, gap_max);
      end else if (gap > 0) gap--;
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
    check({tag, "_busy_held"}, 32'(busy_low), 32'd0);
    check({tag, "_accepts"}, 32'(i), 32'(n_eff));
    check({tag, "_max_idx"}, 32'(max_idx), 32'(e[15:0]));
    check({tag, "_empty"}, 32'(empty), 32'(n_eff == 0));
`ifdef ARGMAX_VAL_EN
    check({tag, "_max_val"}, 32'(max_val), 32'(e[31:16]));
`endif
    if (n_eff == 0) check({tag, "_no_ready"}, 32'(rdy_seen), 32'd0);
    if (gap_max == 0 && n_eff > 0)
      check({tag, "_latency"}, 32'(done_cyc - first_acc), 32'(2 * n_eff - 1));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idx_hold"}, 32'(max_idx), 32'(e[15:0]));
  endtask

  initial begin
    int nr;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_empty", 32'(empty), 32'd0);
    check("rst_max_idx", 32'(max_idx), 32'd0);
`ifdef ARGMAX_VAL_EN
    check("rst_max_val", 32'(max_val), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    items[0] = 16'h3C00; items[1] = 16'h4000; items[2] = 16'hBC00; items[3] = 16'h3C00;
    do_run("basic4", 4, 0, 1'b0);
    items[0] = 16'hBC00; items[1] = 16'hBC00; items[2] = 16'hC000;
    do_run("eqneg", 3, 0, 1'b0);
    do_run("empty", 0, 0, 1'b0);
    items[0] = 16'hC000; items[1] = 16'h3C00; items[2] = 16'h4000;
    do_run("gaps", 3, 5, 1'b1);
    items[0] = 16'h8000; items[1] = 16'h0000;
    do_run("zeros", 2, 0, 1'b0);
    items[0] = 16'h0000; items[1] = 16'h8000;
    do_run("zeros_rev", 2, 0, 1'b0);

    // asynchronous reset while the comparator cycle of an 8-item run is in flight
    @(posedge clk); #1;
    start = 1'b1; n_items = 5'd8; in_valid = 1'b1; in_data = 16'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; in_data = 16'($urandom); end
    check("midrun_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    nr = 0;
    repeat (3) begin @(negedge clk); if (done) nr++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done) nr++; end
    check("midrun_no_done", 32'(nr), 32'd0);
    items[0] = 16'h0000;
    do_run("after_rst", 1, 0, 1'b0);

    for (int k = 0; k < 32; k++) items[k] = 16'($urandom);
    do_run("clamp", 20, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NMAX; k++)
        items[k] = ($urandom_range(0, 2) == 0) ? 16'h4000 ^ {15'd0, 1'($urandom)} << 15 : 16'($urandom);
      nr = (r < 3) ? NMAX : $urandom_range(1, NMAX);
      do_run("rand", nr, (r % 2 == 0) ? 0 : 3, 1'(r % 3 == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
